// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for the M stage of the core.
// Each access takes a fixed number of wait states, then produces a one-cycle
// memReady pulse. Storage is word-aligned, and misaligned accesses are flagged.
// While an access is outstanding, a stall request is sent to the hazard logic.

module data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memReq,
    input  logic                  memWriteM,
    input  logic [31:0]           aluOutM,
    input  logic [31:0]           writeDataM,
    output logic [31:0]           readDataM,
    output logic                  memReady,
    output logic                  alignErr,
    output logic                  stallMem,
    input  logic [DEPTH_LOG2-1:0] testAddr,
    output logic [31:0]           testDataOut
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The accept edge already spends one wait state, so the counter is
    // loaded with one less than WAIT_STATES.
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  align_err_q, align_err_d;
    logic [31:0]           mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic                  commit;
    logic                  mem_we;
    logic                  unused_addr_bits;

    // Upper address bits are ignored, so addresses alias across the memory.
    assign word_idx         = aluOutM[DEPTH_LOG2+1:2];
    assign misaligned       = |aluOutM[1:0];
    assign unused_addr_bits = ^aluOutM[31:DEPTH_LOG2+2];

    // Compute the next FSM state, the response registers and the commit strobe.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        read_data_d = read_data_q;
        mem_ready_d = 1'b0;
        align_err_d = 1'b0;
        commit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (memReq) begin
                    if (WAIT_STATES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        count_d = WS_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!memReq) begin
                    state_d = ST_IDLE;
                end else if (count_q == 4'd0) begin
                    commit = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (commit) begin
            state_d     = ST_RESP;
            mem_ready_d = 1'b1;
            align_err_d = misaligned;
            if (misaligned) begin
                read_data_d = 32'd0;
            end else if (!memWriteM) begin
                read_data_d = mem_q[word_idx];
            end
        end
    end

    // Only an aligned store writes the RAM. Reset discards a store that is pending.
    assign mem_we = commit & memWriteM & ~misaligned & ~rst;

    // Register the FSM state and the responses. Reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 4'd0;
            read_data_q <= 32'd0;
            mem_ready_q <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            align_err_q <= align_err_d;
        end
    end

    // RAM write port. The RAM has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= writeDataM;
        end
    end

    assign readDataM   = read_data_q;
    assign memReady    = mem_ready_q;
    assign alignErr    = align_err_q;
    assign stallMem    = memReq & ~mem_ready_q & ~rst;
    assign testDataOut = mem_q[testAddr];

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder.
// One instance uses 2 wait states and a second uses 0 wait states.
// Stimulus tasks push the expected responses into queues, and the
// monitors pop and compare them whenever memReady is seen.

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        aReq, aWrite;
    logic [31:0] aAddr, aWdata, aRead, aTestData;
    logic        aReady, aAlign, aStall;
    logic [7:0]  aTestAddr;

    logic        bReq, bWrite;
    logic [31:0] bAddr, bWdata, bRead, bTestData;
    logic        bReady, bAlign, bStall;
    logic [7:0]  bTestAddr;

    int cyc = 0;
    int checksTotal = 0;
    int checksPassed = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        al;
    } resp_t;

    resp_t qA[$];
    resp_t qB[$];

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) u_dut (
        .clk(clk), .rst(rst), .memReq(aReq), .memWriteM(aWrite),
        .aluOutM(aAddr), .writeDataM(aWdata), .readDataM(aRead),
        .memReady(aReady), .alignErr(aAlign), .stallMem(aStall),
        .testAddr(aTestAddr), .testDataOut(aTestData)
    );

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .memReq(bReq), .memWriteM(bWrite),
        .aluOutM(bAddr), .writeDataM(bWdata), .readDataM(bRead),
        .memReady(bReady), .alignErr(bAlign), .stallMem(bStall),
        .testAddr(bTestAddr), .testDataOut(bTestData)
    );

    // Free-running clock plus a cycle counter. Between posedge k and k+1, cyc equals k.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 2-wait-state instance: every memReady must match the next queued response.
    always @(negedge clk) begin
        if (aReady === 1'b1) begin
            if (qA.size() == 0) begin
                checkOutput("A_unexpected_ready", 32'(qA.size()), 32'd1);
            end else begin
                resp_t r;
                r = qA.pop_front();
                checkOutput("A_ready_cycle", 32'(cyc), 32'(r.cyc));
                checkOutput("A_readData", aRead, r.rd);
                checkOutput("A_alignErr", {31'd0, aAlign}, {31'd0, r.al});
            end
        end
    end

    // Monitor for the 0-wait-state instance.
    always @(negedge clk) begin
        if (bReady === 1'b1) begin
            if (qB.size() == 0) begin
                checkOutput("B_unexpected_ready", 32'(qB.size()), 32'd1);
            end else begin
                resp_t r;
                r = qB.pop_front();
                checkOutput("B_ready_cycle", 32'(cyc), 32'(r.cyc));
                checkOutput("B_readData", bRead, r.rd);
                checkOutput("B_alignErr", {31'd0, bAlign}, {31'd0, r.al});
            end
        end
    end

    // Issue one access in the current cycle, holding it until memReady.
    // On return the bench is in the cycle after memReady, with memReq low.
    task automatic applyStimulus(input bit sel, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRead,
                                 input logic expAlign, input logic [31:0] expTestData);
        int    ws;
        resp_t r;
        ws = sel ? 0 : 2;
        if (sel) begin
            bReq = 1'b1; bWrite = wr; bAddr = addr; bWdata = wdata;
        end else begin
            aReq = 1'b1; aWrite = wr; aAddr = addr; aWdata = wdata;
        end
        r.cyc = cyc + ws + 1;
        r.rd  = expRead;
        r.al  = expAlign;
        if (sel) qB.push_back(r); else qA.push_back(r);
        for (int k = 0; k <= ws; k++) begin
            @(negedge clk);
            checkOutput(sel ? "B_stall_pending" : "A_stall_pending",
                        {31'd0, sel ? bStall : aStall}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput(sel ? "B_stall_at_ready" : "A_stall_at_ready",
                    {31'd0, sel ? bStall : aStall}, 32'd0);
        checkOutput(sel ? "B_testDataOut" : "A_testDataOut",
                    sel ? bTestData : aTestData, expTestData);
        @(posedge clk); #1;
        if (sel) bReq = 1'b0; else aReq = 1'b0;
    endtask

    // Directed sequence: reset, stores/loads, misalignment, abort, reset mid-access, aliasing.
    initial begin
        rst = 1'b1;
        aReq = 1'b1; aWrite = 1'b0; aAddr = 32'd0; aWdata = 32'd0; aTestAddr = 8'd4;
        bReq = 1'b0; bWrite = 1'b0; bAddr = 32'd0; bWdata = 32'd0; bTestAddr = 8'd0;

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_stall_gated", {31'd0, aStall}, 32'd0);
        checkOutput("reset_readData", aRead, 32'd0);
        checkOutput("reset_memReady", {31'd0, aReady}, 32'd0);
        checkOutput("reset_alignErr", {31'd0, aAlign}, 32'd0);
        @(posedge clk); #1;
        aReq = 1'b0;
        rst  = 1'b0;

        $display("[TB] store DEADBEEF @0x10");
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("[TB] load @0x10");
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("load_hold_1", aRead, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("load_hold_2", aRead, 32'hDEADBEEF);
        @(posedge clk); #1;

        $display("[TB] misaligned store @0x13");
        applyStimulus(1'b0, 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1, 32'hDEADBEEF);

        $display("[TB] abort store @0x20, then load");
        aTestAddr = 8'd8;
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h88888888, 32'h0, 1'b0, 32'h88888888);
        aReq = 1'b1; aWrite = 1'b1; aAddr = 32'h20; aWdata = 32'h11111111;
        @(posedge clk); #1;
        aReq = 1'b0;
        @(negedge clk);
        checkOutput("abort_stall", {31'd0, aStall}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 32'h88888888, 1'b0, 32'h88888888);

        $display("[TB] reset during store @0x24");
        aTestAddr = 8'd9;
        applyStimulus(1'b0, 1'b1, 32'h24, 32'h99999999, 32'h88888888, 1'b0, 32'h99999999);
        aReq = 1'b1; aWrite = 1'b1; aAddr = 32'h24; aWdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_stall", {31'd0, aStall}, 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        aReq = 1'b0;
        @(negedge clk);
        checkOutput("rst_readData", aRead, 32'd0);
        checkOutput("rst_memReady", {31'd0, aReady}, 32'd0);
        checkOutput("rst_alignErr", {31'd0, aAlign}, 32'd0);
        checkOutput("rst_ram_kept", aTestData, 32'h99999999);
        @(posedge clk); #1;

        $display("[TB] zero wait states, aliasing @0x400 / @0x000");
        applyStimulus(1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("A_responses_outstanding", 32'(qA.size()), 32'd0);
        checkOutput("B_responses_outstanding", 32'(qB.size()), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
